ldsync_arb: RTL and testbench

Arbitrated write controller for a bank of load-enabled sync registers (fd1e-style hold/load flops) inside Tom. Several internal requesters (CPU bus port, GPU, blitter) contend for the same register bank. The block picks one requester, latches its address and data, and drives a one-cycle one-hot load strobe into the bank. It then returns a one-cycle acknowledge to the winner. The block owns the register bank and exposes all register contents in parallel.

---
 rtl/ldsync_arb_pkg.sv | 30 +++
 rtl/ldsync_arb_pick.sv | 39 +++
 rtl/ldsync_arb.sv | 131 +++++++++++++
 tb/tb_ldsync_arb.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ldsync_arb_pkg.sv
// Shared types, default sizes and address decode helper for the ldsync_arb register-bank writer.
package ldsync_arb_pkg;

  localparam int unsigned NreqDef = 3;
  localparam int unsigned NregDef = 8;
  localparam int unsigned AwDef   = 3;
  localparam int unsigned DwDef   = 16;

  // Upper bound on address width the one-hot helper can decode.
  localparam int unsigned MaxAw  = 8;
  localparam int unsigned MaxReg = 256;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StAck  = 2'd2
  } state_e;

  // One-hot decode of addr; all-zero when addr falls outside the nreg-entry bank.
  function automatic logic [MaxReg-1:0] addr_onehot(input logic [MaxAw-1:0] addr,
                                                    input int unsigned nreg);
    logic [MaxReg-1:0] oh;
    oh = '0;
    if ({24'b0, addr} < nreg) begin
      oh[addr] = 1'b1;
    end
    return oh;
  endfunction

endpackage

// File: rtl/ldsync_arb_pick.sv
// Combinational winner select: round-robin from ptr when LDSYNC_ARB_RR_EN is defined,
// otherwise fixed priority with the lowest index winning.
module ldsync_arb_pick
  import ldsync_arb_pkg::*;
#(
  parameter int unsigned NREQ = NreqDef,
  parameter int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   win,
  output logic            valid
);

  logic [31:0] base;

`ifdef LDSYNC_ARB_RR_EN
  assign base = 32'(ptr);
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;
  assign base = '0;
`endif

  always_comb begin
    int unsigned idx;
    idx   = 0;
    win   = '0;
    valid = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (base + k) % NREQ;
      if (!valid && req[idx]) begin
        valid = 1'b1;
        win   = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/ldsync_arb.sv
// Arbitrated load-strobe writer for a bank of hold/load registers; arbitration variant is
// selected by LDSYNC_ARB_RR_EN (round-robin when defined, fixed priority otherwise).
module ldsync_arb
  import ldsync_arb_pkg::*;
#(
  parameter int unsigned NREQ = NreqDef,
  parameter int unsigned NREG = NregDef,
  parameter int unsigned AW   = AwDef,
  parameter int unsigned DW   = DwDef
) (
  input  logic               sys_clk,
  input  logic               resetl,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] wr_addr,
  input  logic [NREQ*DW-1:0] wr_data,
  output logic [NREQ-1:0]    ack,
  output logic               err,
  output logic               busy,
  output logic [NREG-1:0]    ld,
  output logic [NREG*DW-1:0] q
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e                   state_q;
  logic [IW-1:0]            win_q;
  logic [DW-1:0]            data_q;
  logic [NREG-1:0]          ld_q;
  logic [NREQ-1:0]          ack_q;
  logic                     err_q;
  logic [NREG-1:0][DW-1:0]  bank_q;
  logic [IW-1:0]            ptr;

  logic [IW-1:0]            pick_win;
  logic                     pick_valid;
  logic [AW-1:0]            sel_addr;
  logic [DW-1:0]            sel_data;
  logic [NREG-1:0]          ld_next;

  ldsync_arb_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .win   (pick_win),
    .valid (pick_valid)
  );

  assign sel_addr = wr_addr[pick_win*AW +: AW];
  assign sel_data = wr_data[pick_win*DW +: DW];
  assign ld_next  = NREG'(addr_onehot(MaxAw'(sel_addr), NREG));

`ifdef LDSYNC_ARB_RR_EN
  logic [IW-1:0] ptr_q;

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      ptr_q <= '0;
    end else if (state_q == StIdle && pick_valid) begin
      ptr_q <= (pick_win == IW'(NREQ - 1)) ? '0 : pick_win + 1'b1;
    end
  end

  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  // The strobe is decoded while latching so that ld is a plain register during LOAD.
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      state_q <= StIdle;
      win_q   <= '0;
      data_q  <= '0;
      ld_q    <= '0;
      ack_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      ld_q  <= '0;
      ack_q <= '0;
      err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pick_valid) begin
            win_q   <= pick_win;
            data_q  <= sel_data;
            ld_q    <= ld_next;
            state_q <= StLoad;
          end
        end
        StLoad: begin
          ack_q[win_q] <= 1'b1;
          // An empty strobe means the latched address missed the bank.
          err_q        <= (ld_q == '0);
          state_q      <= StAck;
        end
        StAck: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      bank_q <= '0;
    end else begin
      for (int unsigned r = 0; r < NREG; r++) begin
        if (ld_q[r]) begin
          bank_q[r] <= data_q;
        end
      end
    end
  end

  assign ld   = ld_q;
  assign ack  = ack_q;
  assign err  = err_q;
  assign busy = (state_q != StIdle);
  assign q    = bank_q;

  a_ld_onehot0 : assert property (@(posedge sys_clk) disable iff (!resetl) $onehot0(ld_q));
  a_ack_onehot0 : assert property (@(posedge sys_clk) disable iff (!resetl) $onehot0(ack_q));
  a_ld_in_load : assert property (@(posedge sys_clk) disable iff (!resetl)
                                  (ld_q != '0) |-> (state_q == StLoad));

endmodule

// File: tb/tb_ldsync_arb.sv
// Directed self-checking bench for ldsync_arb (NREQ=3, NREG=6, AW=3, DW=16).
module tb_ldsync_arb;

  localparam int unsigned NREQ = 3;
  localparam int unsigned NREG = 6;
  localparam int unsigned AW   = 3;
  localparam int unsigned DW   = 16;

  logic                 sys_clk;
  logic                 resetl;
  logic [NREQ-1:0]      req;
  logic [NREQ*AW-1:0]   wr_addr;
  logic [NREQ*DW-1:0]   wr_data;
  logic [NREQ-1:0]      ack;
  logic                 err;
  logic                 busy;
  logic [NREG-1:0]      ld;
  logic [NREG*DW-1:0]   q;

  int n_checks;
  int n_errors;
  int cyc;
  int grants[$];
  logic [NREG*DW-1:0] exp_q;
  int t1;
  int t2;

  ldsync_arb #(
    .NREQ (NREQ),
    .NREG (NREG),
    .AW   (AW),
    .DW   (DW)
  ) dut (
    .sys_clk (sys_clk),
    .resetl  (resetl),
    .req     (req),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .ack     (ack),
    .err     (err),
    .busy    (busy),
    .ld      (ld),
    .q       (q)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "bench timeout");
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    resetl = 1'b0;
    req    = '0;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    resetl = 1'b1;
    step();
  endtask

  task automatic set_wr(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_addr[i*AW +: AW] = a;
    wr_data[i*DW +: DW] = d;
  endtask

  // Requesters drop req on the cycle they see ack unless marked sticky.
  task automatic run_req(input logic [NREQ-1:0] sticky, input int ncycles);
    for (int c = 0; c < ncycles; c++) begin
      step();
      for (int i = 0; i < int'(NREQ); i++) begin
        if (ack[i]) begin
          grants.push_back(i);
          if (!sticky[i]) req[i] = 1'b0;
        end
      end
    end
  endtask

  function automatic int grant_at(input int k);
    return (grants.size() > k) ? grants[k] : 99;
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    req      = '0;
    wr_addr  = '0;
    wr_data  = '0;
    resetl   = 1'b0;
    #2;
    check_eq("rst_ld", ld, 0);
    check_eq("rst_ack", ack, 0);
    check_eq("rst_busy", busy, 0);
    do_reset();
    check_eq("rst_q", q, 0);
    check_eq("rst_err", err, 0);

    // Single write: requester 1, reg 3 <= BEEF
    set_wr(1, 3'd3, 16'hBEEF);
    req = 3'b010;
    step();
    check_eq("single_ld", ld, 6'h08);
    check_eq("single_busy", busy, 1);
    check_eq("single_ack_early", ack, 0);
    step();
    exp_q = '0;
    exp_q[3*DW +: DW] = 16'hBEEF;
    check_eq("single_ack", ack, 3'b010);
    check_eq("single_err", err, 0);
    check_eq("single_q", q, exp_q);
    check_eq("single_ld_off", ld, 0);
    req = '0;
    step();
    check_eq("single_idle_busy", busy, 0);
    check_eq("single_idle_ack", ack, 0);

    // Contention: all three held, each drops on its own ack
    do_reset();
    set_wr(0, 3'd0, 16'h0A00);
    set_wr(1, 3'd1, 16'h0A01);
    set_wr(2, 3'd2, 16'h0A02);
    grants.delete();
    req = 3'b111;
    run_req(3'b000, 12);
    check_eq("cont_n", grants.size(), 3);
    check_eq("cont_g0", grant_at(0), 0);
    check_eq("cont_g1", grant_at(1), 1);
    check_eq("cont_g2", grant_at(2), 2);
    exp_q = '0;
    exp_q[0*DW +: DW] = 16'h0A00;
    exp_q[1*DW +: DW] = 16'h0A01;
    exp_q[2*DW +: DW] = 16'h0A02;
    check_eq("cont_q", q, exp_q);
    grants.delete();
    req = 3'b111;
    run_req(3'b000, 12);
    check_eq("cont2_n", grants.size(), 3);
    check_eq("cont2_g0", grant_at(0), 0);
    check_eq("cont2_g1", grant_at(1), 1);
    check_eq("cont2_g2", grant_at(2), 2);

    // Requester 0 never lets go
    do_reset();
    grants.delete();
    req = 3'b111;
    run_req(3'b001, 9);
    check_eq("hold_n", grants.size(), 3);
`ifdef LDSYNC_ARB_RR_EN
    check_eq("hold_g0", grant_at(0), 0);
    check_eq("hold_g1", grant_at(1), 1);
    check_eq("hold_g2", grant_at(2), 2);
`else
    check_eq("hold_g0", grant_at(0), 0);
    check_eq("hold_g1", grant_at(1), 0);
    check_eq("hold_g2", grant_at(2), 0);
    check_eq("hold_starved", req, 3'b111);
`endif

    // Out-of-range address after a valid write
    do_reset();
    set_wr(0, 3'd5, 16'h5555);
    req = 3'b001;
    step();
    check_eq("oor_pre_ld", ld, 6'h20);
    step();
    req = '0;
    step();
    exp_q = '0;
    exp_q[5*DW +: DW] = 16'h5555;
    set_wr(0, 3'd7, 16'h1234);
    req = 3'b001;
    step();
    check_eq("oor_ld", ld, 0);
    check_eq("oor_busy", busy, 1);
    check_eq("oor_err_early", err, 0);
    step();
    check_eq("oor_ack", ack, 3'b001);
    check_eq("oor_err", err, 1);
    check_eq("oor_q", q, exp_q);
    req = '0;
    step();
    check_eq("oor_err_off", err, 0);
    check_eq("oor_ack_off", ack, 0);

    // Withdrawal after grant
    set_wr(2, 3'd1, 16'hA5A5);
    req = 3'b100;
    step();
    check_eq("wd_ld", ld, 6'h02);
    req = '0;
    step();
    exp_q[1*DW +: DW] = 16'hA5A5;
    check_eq("wd_ack", ack, 3'b100);
    check_eq("wd_q", q, exp_q);
    step();
    step();
    check_eq("wd_no_repeat", busy, 0);

    // Reset during LOAD with the request still pending
    set_wr(1, 3'd2, 16'h7777);
    req = 3'b010;
    step();
    check_eq("mid_ld_pre", ld, 6'h04);
    resetl = 1'b0;
    #1;
    check_eq("mid_ld", ld, 0);
    check_eq("mid_ack", ack, 0);
    check_eq("mid_busy", busy, 0);
    check_eq("mid_q", q, 0);
    @(negedge sys_clk);
    resetl = 1'b1;
    step();
    check_eq("mid_retry_ld", ld, 6'h04);
    step();
    exp_q = '0;
    exp_q[2*DW +: DW] = 16'h7777;
    check_eq("mid_retry_ack", ack, 3'b010);
    check_eq("mid_retry_q", q, exp_q);
    req = '0;
    step();

    // Back-to-back: requester keeps req high through its ack
    set_wr(0, 3'd0, 16'h1111);
    req = 3'b001;
    step();
    check_eq("b2b_ld1", ld, 6'h01);
    t1 = cyc;
    step();
    check_eq("b2b_ack1", ack, 3'b001);
    set_wr(0, 3'd4, 16'h2222);
    step();
    check_eq("b2b_gap_ld", ld, 0);
    step();
    check_eq("b2b_ld2", ld, 6'h10);
    t2 = cyc;
    check_eq("b2b_spacing", t2 - t1, 3);
    step();
    exp_q[0*DW +: DW] = 16'h1111;
    exp_q[4*DW +: DW] = 16'h2222;
    check_eq("b2b_ack2", ack, 3'b001);
    check_eq("b2b_q", q, exp_q);
    req = '0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
